// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter
// Round-robin scheduler that time-shares one multiply-accumulate engine
// between the post-CIC decimation stages (0 = FIR, 1 = HB1, 2 = HB2).
// Each requester can hold one pending job. A granted job runs for len
// cycles, drives the MAC control strobes, and then pulses done for one cycle.
//
// Ports
//   clk      : system clock; all logic uses the rising edge
//   rst      : asynchronous, active-high reset
//   req      : one-cycle job-request strobe per requester
//   req_len  : tap count per requester, slice i = [i*LEN_W +: LEN_W]
//   clr_err  : synchronous clear of the sticky overrun flags
//   gnt      : one-hot grant, high for the whole job of the served requester
//   mac_sel  : index of the served requester (holds its last value)
//   mac_en   : MAC performs one tap this cycle
//   mac_clr  : first tap of a job (accumulator load)
//   mac_idx  : tap index 0..len-1
//   mac_last : final tap of the job
//   done     : one-cycle completion pulse per requester
//   busy     : arbiter is not idle
//   overrun  : sticky flag, a request arrived while one was already pending
module mac_share_arbiter #(
  parameter  int NUM_REQ = 3,
  parameter  int LEN_W   = 5,
  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     clr_err,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]         mac_sel,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic [LEN_W-1:0]         mac_idx,
  output logic                     mac_last,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [LEN_W-1:0]   len_q [NUM_REQ];
  logic [LEN_W-1:0]   len_d [NUM_REQ];
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               en_q, en_d;
  logic               clr_q, clr_d;
  logic               lastb_q, lastb_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] ovr_q, ovr_d;
  logic [NUM_REQ-1:0] ovr_set;

  logic [LEN_W-1:0]   len_in [NUM_REQ];
  logic               found;
  logic [SEL_W-1:0]   win;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_len_slice
      assign len_in[gi] = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int c;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last_q) + k) % NUM_REQ;
      if (!found && pend_q[c]) begin
        found = 1'b1;
        win   = SEL_W'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    len_d   = len_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    en_d    = en_q;
    clr_d   = clr_q;
    lastb_d = lastb_q;
    done_d  = '0;
    ovr_set = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          pend_d[win] = 1'b0;
          last_d      = win;
          gnt_d       = NUM_REQ'(1) << win;
          sel_d       = win;
          cnt_d       = len_q[win] - 1'b1;
          idx_d       = '0;
          en_d        = 1'b1;
          clr_d       = 1'b1;
          lastb_d     = (len_q[win] == LEN_W'(1));
          state_d     = RUN;
        end
      end
      RUN: begin
        if (idx_q == cnt_q) begin
          state_d       = DONE;
          gnt_d         = '0;
          en_d          = 1'b0;
          clr_d         = 1'b0;
          lastb_d       = 1'b0;
          idx_d         = '0;
          done_d[sel_q] = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          clr_d   = 1'b0;
          lastb_d = ((idx_q + 1'b1) == cnt_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture runs after the grant clear so that a strobe arriving on the
    // grant cycle of the same requester re-queues it instead of overrunning.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (len_in[i] != '0)) begin
        if (pend_d[i]) begin
          ovr_set[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          len_d[i]  = len_in[i];
        end
      end
    end

    // A new overrun event beats a simultaneous clear.
    ovr_d = (ovr_q & ~{NUM_REQ{clr_err}}) | ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) len_q[i] <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      lastb_q <= 1'b0;
      done_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      lastb_q <= lastb_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign gnt      = gnt_q;
  assign mac_sel  = sel_q;
  assign mac_en   = en_q;
  assign mac_clr  = clr_q;
  assign mac_idx  = idx_q;
  assign mac_last = lastb_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_mac_share_arbiter.sv
module tb_mac_share_arbiter;

  localparam int NUM_REQ = 3;
  localparam int LEN_W   = 5;
  localparam int SEL_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     clr_err;
  logic [NUM_REQ-1:0]       gnt;
  logic [SEL_W-1:0]         mac_sel;
  logic                     mac_en;
  logic                     mac_clr;
  logic [LEN_W-1:0]         mac_idx;
  logic                     mac_last;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [NUM_REQ-1:0]       overrun;

  mac_share_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .clr_err(clr_err),
    .gnt(gnt), .mac_sel(mac_sel), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_idx(mac_idx), .mac_last(mac_last), .done(done), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: pending jobs, round-robin pointer and the job in
  // service described by its start-relative cycle count j_t.
  // j_t in 0..j_len-1 is a tap cycle, j_t == j_len is the done cycle.
  bit [NUM_REQ-1:0] m_pend;
  int               m_len [NUM_REQ];
  int               m_last;
  bit [NUM_REQ-1:0] m_ovr;
  bit               in_job;
  int               j_req, j_len, j_t;
  int               m_sel;

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < NUM_REQ; i++) m_len[i] = 0;
    m_last = NUM_REQ - 1;
    m_ovr  = '0;
    in_job = 1'b0;
    j_req  = 0;
    j_len  = 0;
    j_t    = 0;
    m_sel  = 0;
  endtask

  task automatic model_edge();
    bit [NUM_REQ-1:0] new_ovr;
    int l;
    new_ovr = '0;
    if (in_job) begin
      j_t++;
      if (j_t > j_len) in_job = 1'b0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!in_job && m_pend[c]) begin
          in_job    = 1'b1;
          j_req     = c;
          j_len     = m_len[c];
          j_t       = 0;
          m_pend[c] = 1'b0;
          m_last    = c;
          m_sel     = c;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      l = int'(req_len[i*LEN_W +: LEN_W]);
      if (req[i] && l != 0) begin
        if (m_pend[i]) new_ovr[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_len[i]  = l;
        end
      end
    end
    m_ovr = (clr_err ? '0 : m_ovr) | new_ovr;
  endtask

  task automatic check_outputs();
    bit run, dn;
    run = in_job && (j_t < j_len);
    dn  = in_job && (j_t == j_len);
    check("gnt",      32'(gnt),      run ? (32'd1 << j_req) : 32'd0);
    check("mac_sel",  32'(mac_sel),  32'(m_sel));
    check("mac_en",   32'(mac_en),   32'(run));
    check("mac_clr",  32'(mac_clr),  32'(run && j_t == 0));
    check("mac_idx",  32'(mac_idx),  run ? 32'(j_t) : 32'd0);
    check("mac_last", 32'(mac_last), 32'(run && j_t == j_len - 1));
    check("done",     32'(done),     dn ? (32'd1 << j_req) : 32'd0);
    check("busy",     32'(busy),     32'(in_job));
    check("overrun",  32'(overrun),  32'(m_ovr));
  endtask

  function automatic logic [NUM_REQ*LEN_W-1:0] lens(input int a, input int b, input int c);
    logic [LEN_W-1:0] la, lb, lc;
    la = LEN_W'(a);
    lb = LEN_W'(b);
    lc = LEN_W'(c);
    return {lc, lb, la};
  endfunction

  // One clock cycle: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] l, input logic c);
    req     = r;
    req_len = l;
    clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    req     = '0;
    clr_err = 1'b0;
    check_outputs();
    $display("cyc t=%0t req=%b gnt=%b en=%b idx=%0d clr=%b last=%b done=%b busy=%b ovr=%b",
             $time, r, gnt, mac_en, mac_idx, mac_clr, mac_last, done, busy, overrun);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_len = '0;
    clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single job, len 4
    step(3'b001, lens(4, 0, 0), 1'b0);
    idle(8);

    // Simultaneous requests, len 2 each
    step(3'b111, lens(2, 2, 2), 1'b0);
    idle(14);

    // Fairness: requester 1 in service, then 0 and 2 strobed
    step(3'b010, lens(0, 3, 0), 1'b0);
    idle(2);
    step(3'b101, lens(2, 0, 2), 1'b0);
    idle(16);

    // Overrun on requester 1 while it waits behind a long job
    step(3'b001, lens(6, 0, 0), 1'b0);
    step('0, '0, 1'b0);
    step(3'b010, lens(0, 3, 0), 1'b0);
    step(3'b010, lens(0, 3, 0), 1'b0);
    idle(15);
    step('0, '0, 1'b1);
    idle(1);
    // Overrun and clear in the same cycle
    step(3'b001, lens(6, 0, 0), 1'b0);
    step('0, '0, 1'b0);
    step(3'b010, lens(0, 2, 0), 1'b0);
    step(3'b010, lens(0, 2, 0), 1'b1);
    idle(16);
    step('0, '0, 1'b1);

    // Zero-length request ignored; single-tap job
    step(3'b100, lens(0, 0, 0), 1'b0);
    idle(3);
    step(3'b001, lens(1, 0, 0), 1'b0);
    idle(4);

    // Reset during RUN of requester 1 with requester 2 pending
    step(3'b010, lens(0, 8, 0), 1'b0);
    step('0, '0, 1'b0);
    step(3'b100, lens(0, 0, 3), 1'b0);
    step('0, '0, 1'b0);
    async_reset();
    step(3'b100, lens(0, 0, 2), 1'b0);
    idle(6);
    step(3'b111, lens(3, 1, 2), 1'b0);
    idle(15);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_REQ-1:0] r;
      for (int i = 0; i < NUM_REQ; i++) r[i] = ($urandom_range(0, 3) == 0);
      step(r, lens($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)),
           ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
